bcd_count4: RTL and testbench
=============================

# bcd_count4

Four-digit BCD up/down counter with prescaled step tick, run/stop toggle, synchronous clear and parallel load. It sits directly upstream of four instances of the team's 7-segment decoder: each digit's nibble drives a decoder `DIN`, and each digit's enable drives that decoder's `EN` so leading zeros show blank. Typical use is a board-level counter or stopwatch display.

## Interface
Parameters:
- `PRESCALE`, default 50_000_000: CLK cycles per count step; legal range ≥ 2.
- `BLANK`, default 1: 1 blanks leading zeros via `EN`; 0 keeps all four digits enabled.

Ports:
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `START`  in  1  asynchronous pushbutton level; each rising edge toggles `RUN`.
- `CLR`  in  1  synchronous clear.
- `LOAD`  in  1  synchronous parallel load.
- `LDVAL`  in  16  BCD load value; `[3:0]` is digit 0 (least significant).
- `DOWN`  in  1  direction: 0 counts up, 1 counts down; sampled at each step.
- `DIGIT`  out  16  current BCD value; nibble i feeds decoder i `DIN`.
- `EN`  out  4  per-digit decoder enable.
- `RUN`  out  1  1 while counting.
- `CARRY`  out  1  one-cycle pulse on wrap, in either direction.

## Operation
- **Reset:**
  - `DIGIT`=0x0000, `RUN`=0, `CARRY`=0, prescaler=0.
  - `EN`=4'b0001 if `BLANK`=1, else 4'b1111.
- **START path:** 2-flop synchronizer, then a registered previous value. A rising edge (sync2 & ~prev) toggles `RUN`.
- **Prescaler:**
  - Counts 0..`PRESCALE`-1 only while `RUN`=1. It holds its value while stopped, so a resumed count continues mid-period.
  - Step event = `RUN` & (prescaler==`PRESCALE`-1). The prescaler wraps to 0 on the step.
- **Priority per cycle:** `CLR` > `LOAD` > step.
  - `CLR`: `DIGIT`←0, prescaler←0. `RUN` is unchanged.
  - `LOAD`: `DIGIT`←`LDVAL` with each nibble >9 clamped to 9; prescaler←0. `RUN` is unchanged.
  - A step in the same cycle as `CLR` or `LOAD` is discarded. `CARRY` stays 0 in that cycle.
- **Step up:**
  - Digit 0 increments. Any digit at 9 becomes 0 and carries into the next digit.
  - 9999 → 0000 with `CARRY`=1.
- **Step down:**
  - Digit 0 decrements. Any digit at 0 becomes 9 and borrows from the next digit.
  - 0000 → 9999 with `CARRY`=1.
- `DIGIT` always holds valid BCD: every nibble is ≤9 after any operation.
- **`EN` with `BLANK`=1:**
  - `EN[0]`=1 always.
  - `EN[i]`=1 iff any digit j≥i is nonzero (i=1..3).
- **`EN` with `BLANK`=0:** all ones.
- `RST` asserted mid-count returns every output to its reset value immediately (asynchronous). Counting restarts only after a new `START` edge.

## Timing
- `RUN` toggles on the 3rd rising `CLK` edge after `START` first samples high. The `START` high level must last ≥3 cycles. Debouncing is out of scope.
- With `RUN` held at 1, `DIGIT` changes exactly once every `PRESCALE` cycles. The first step comes `PRESCALE` cycles after `RUN` rises from a zero prescaler.
- `CLR` and `LOAD` take effect at the next edge (1-cycle latency).
- `CARRY` is registered and coincident with the wrapped `DIGIT` value, high for exactly one cycle.
- `DIGIT`, `RUN` and `CARRY` are registered outputs. `EN` is combinational from the `DIGIT` register only, with no path from inputs.

## Structure
- Shared package `disp_pkg` holds:
  - `BCD_MAX` = 4'd9
  - `NDIG` = 4
  - typedef `bcd_t` (logic [3:0])
- Sub-module `bcd_digit`: one digit cell with inputs `inc`, `dec`, `clr`, `ld`, `ldval`. It outputs the digit value and `co`/`bo` (carry-out at 9 on inc, borrow-out at 0 on dec).
  - The top module instantiates 4 cells in a chain: the cell's step input is AND-ed with the lower cell's `co`/`bo`.
  - `CARRY` is derived from the top cell's `co` or `bo`.
- Prescaler, START synchronizer and `EN` logic live in the top module.

## Test plan
Unless noted, benches use `PRESCALE`=4.
- **Reset/blank:** assert `RST` → `DIGIT`=0x0000, `EN`=4'b0001, `RUN`=0, `CARRY`=0.
- **Run and count:** `START` pulse of 3 cycles → `RUN`=1 on the 3rd edge. After 40 cycles, `DIGIT`=0x0010 and `EN`=4'b0011.
- **Up wrap:**
  - `LOAD` `LDVAL`=0x9998, run up → 0x9999, then 0x0000 with `CARRY` high exactly 1 cycle.
  - `EN` goes 1111 → 0001.
- **Down wrap and clamp:**
  - `LOAD` 0x0001, `DOWN`=1 → 0x0000, then 0x9999 with `CARRY`=1.
  - `LOAD` 0xFA3C → `DIGIT`=0x9939.
- **Priority:** `CLR` and `LOAD` asserted in the same cycle as a step → `DIGIT`=0x0000, no `CARRY`, prescaler restarts (next step 4 cycles later).
- **Stop/resume and mid-run reset:**
  - Second `START` edge → `RUN`=0 and `DIGIT` frozen; restart resumes from the held prescaler count.
  - Async `RST` between clock edges → outputs return to reset values before the next edge.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the BCD display-driver blocks.
package disp_pkg;

    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam int unsigned NDIG    = 4;

    typedef logic [3:0] bcd_t;

    // Any nibble above 9 saturates to 9 so loaded values stay valid BCD.
    function automatic bcd_t bcd_clamp(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit cell: clear > load > inc/dec, with combinational carry/borrow out.
module bcd_digit
    import disp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    input  logic ld,
    input  bcd_t ldval,
    output bcd_t q,
    output logic co,
    output logic bo
);

    bcd_t value_q;

    assign co = inc & (value_q == BCD_MAX);
    assign bo = dec & (value_q == 4'd0);
    assign q  = value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else if (clr) begin
            value_q <= '0;
        end else if (ld) begin
            value_q <= bcd_clamp(ldval);
        end else if (inc) begin
            value_q <= co ? 4'd0 : value_q + 4'd1;
        end else if (dec) begin
            value_q <= bo ? BCD_MAX : value_q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_count4.sv
// Four-digit BCD up/down counter with prescaled step, START run toggle, clear and load.
module bcd_count4
    import disp_pkg::*;
#(
    parameter int unsigned PRESCALE = 50_000_000,
    parameter bit          BLANK    = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        CLR,
    input  logic        LOAD,
    input  logic [15:0] LDVAL,
    input  logic        DOWN,
    output logic [15:0] DIGIT,
    output logic [3:0]  EN,
    output logic        RUN,
    output logic        CARRY
);

    localparam int unsigned     PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

    logic          start_s1, start_s2, start_prev;
    logic          run_q, carry_q;
    logic [PW-1:0] pre_q;
    logic          pre_wrap, step, step_up, step_dn;
    logic          top_co, top_bo;
    logic [3:0]    nz;

    assign pre_wrap = (pre_q == PRE_LAST);
    // Clear and load swallow a coincident step, which also keeps CARRY low.
    assign step     = run_q & pre_wrap & ~CLR & ~LOAD;
    assign step_up  = step & ~DOWN;
    assign step_dn  = step & DOWN;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        logic inc_in, dec_in, co, bo;
        if (i == 0) begin : g_lsd
            assign inc_in = step_up;
            assign dec_in = step_dn;
        end else begin : g_chain
            assign inc_in = step_up & g_dig[i-1].co;
            assign dec_in = step_dn & g_dig[i-1].bo;
        end
        bcd_digit u_digit (
            .clk   (CLK),
            .rst   (RST),
            .inc   (inc_in),
            .dec   (dec_in),
            .clr   (CLR),
            .ld    (LOAD),
            .ldval (LDVAL[4*i +: 4]),
            .q     (DIGIT[4*i +: 4]),
            .co    (co),
            .bo    (bo)
        );
    end

    assign top_co = g_dig[NDIG-1].co;
    assign top_bo = g_dig[NDIG-1].bo;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_prev <= 1'b0;
            run_q      <= 1'b0;
            pre_q      <= '0;
            carry_q    <= 1'b0;
        end else begin
            start_s1   <= START;
            start_s2   <= start_s1;
            start_prev <= start_s2;
            if (start_s2 && !start_prev) begin
                run_q <= ~run_q;
            end
            // Prescaler holds while stopped so a resumed run continues mid-period.
            if (CLR || LOAD) begin
                pre_q <= '0;
            end else if (run_q) begin
                pre_q <= pre_wrap ? '0 : pre_q + 1'b1;
            end
            carry_q <= top_co | top_bo;
        end
    end

    always_comb begin
        nz[0] = |DIGIT[3:0];
        nz[1] = |DIGIT[7:4];
        nz[2] = |DIGIT[11:8];
        nz[3] = |DIGIT[15:12];
        if (BLANK) begin
            EN = {nz[3], nz[3] | nz[2], nz[3] | nz[2] | nz[1], 1'b1};
        end else begin
            EN = 4'b1111;
        end
    end

    assign RUN   = run_q;
    assign CARRY = carry_q;

endmodule

// File: tb/tb_bcd_count4.sv
// Directed self-checking bench for bcd_count4 with PRESCALE=4, BLANK=1.
module tb_bcd_count4;

    logic        CLK, RST, START, CLR, LOAD, DOWN;
    logic [15:0] LDVAL;
    logic [15:0] DIGIT;
    logic [3:0]  EN;
    logic        RUN, CARRY;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_count4 #(
        .PRESCALE (4),
        .BLANK    (1'b1)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .CLR   (CLR),
        .LOAD  (LOAD),
        .LDVAL (LDVAL),
        .DOWN  (DOWN),
        .DIGIT (DIGIT),
        .EN    (EN),
        .RUN   (RUN),
        .CARRY (CARRY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; CLR = 1'b0; LOAD = 1'b0; DOWN = 1'b0; LDVAL = 16'h0000;

        // Reset state
        tick(2);
        chk("rst_digit", DIGIT, 16'h0000);
        chk("rst_en",    {12'd0, EN}, 16'h0001);
        chk("rst_run",   {15'd0, RUN}, 16'h0000);
        chk("rst_carry", {15'd0, CARRY}, 16'h0000);
        RST = 1'b0;
        tick(2);

        // START held 3 cycles: RUN rises on the 3rd edge
        START = 1'b1;
        tick(2);
        chk("run_edge2", {15'd0, RUN}, 16'h0000);
        tick(1);
        chk("run_edge3", {15'd0, RUN}, 16'h0001);
        START = 1'b0;
        tick(3);
        chk("first_step_pre", DIGIT, 16'h0000);
        tick(1);
        chk("first_step", DIGIT, 16'h0001);
        tick(36);
        chk("count40_digit", DIGIT, 16'h0010);
        chk("count40_en",    {12'd0, EN}, 16'h0003);

        // Up wrap
        LOAD = 1'b1; LDVAL = 16'h9998;
        tick(1);
        LOAD = 1'b0;
        chk("load_9998", DIGIT, 16'h9998);
        tick(4);
        chk("up_9999",    DIGIT, 16'h9999);
        chk("up_9999_en", {12'd0, EN}, 16'h000F);
        tick(3);
        chk("up_hold_carry", {15'd0, CARRY}, 16'h0000);
        tick(1);
        chk("up_wrap_digit", DIGIT, 16'h0000);
        chk("up_wrap_carry", {15'd0, CARRY}, 16'h0001);
        chk("up_wrap_en",    {12'd0, EN}, 16'h0001);
        tick(1);
        chk("up_carry_drop", {15'd0, CARRY}, 16'h0000);

        // Down wrap (prescaler is 1 here; load restarts it)
        LOAD = 1'b1; LDVAL = 16'h0001; DOWN = 1'b1;
        tick(1);
        LOAD = 1'b0;
        tick(4);
        chk("dn_0000",       DIGIT, 16'h0000);
        chk("dn_0000_carry", {15'd0, CARRY}, 16'h0000);
        tick(4);
        chk("dn_wrap_digit", DIGIT, 16'h9999);
        chk("dn_wrap_carry", {15'd0, CARRY}, 16'h0001);
        tick(1);
        chk("dn_carry_drop", {15'd0, CARRY}, 16'h0000);

        // Clamp on load
        LOAD = 1'b1; LDVAL = 16'hFA3C;
        tick(1);
        LOAD = 1'b0; DOWN = 1'b0;
        chk("clamp", DIGIT, 16'h9939);

        // CLR and LOAD together on a step cycle (prescaler at 3 after 3 ticks)
        tick(3);
        chk("prio_pre_step", DIGIT, 16'h9939);
        CLR = 1'b1; LOAD = 1'b1; LDVAL = 16'h1234;
        tick(1);
        CLR = 1'b0; LOAD = 1'b0;
        chk("prio_clr_digit", DIGIT, 16'h0000);
        chk("prio_clr_carry", {15'd0, CARRY}, 16'h0000);
        tick(3);
        chk("prio_restart_hold", DIGIT, 16'h0000);
        tick(1);
        chk("prio_restart_step", DIGIT, 16'h0001);

        // LOAD alone on a step cycle
        tick(3);
        LOAD = 1'b1; LDVAL = 16'h0500;
        tick(1);
        LOAD = 1'b0;
        chk("prio_load", DIGIT, 16'h0500);
        tick(4);
        chk("load_then_step", DIGIT, 16'h0501);

        // Stop: prescaler advances to 3 during the toggle latency, then holds
        START = 1'b1;
        tick(3);
        START = 1'b0;
        chk("stop_run", {15'd0, RUN}, 16'h0000);
        tick(10);
        chk("stop_frozen", DIGIT, 16'h0501);
        chk("stop_run_hold", {15'd0, RUN}, 16'h0000);

        // Resume: held prescaler count gives a step one cycle after RUN rises
        START = 1'b1;
        tick(3);
        START = 1'b0;
        chk("resume_run",   {15'd0, RUN}, 16'h0001);
        chk("resume_digit", DIGIT, 16'h0501);
        tick(1);
        chk("resume_step", DIGIT, 16'h0502);

        // Asynchronous reset between edges
        tick(1);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_digit", DIGIT, 16'h0000);
        chk("arst_run",   {15'd0, RUN}, 16'h0000);
        chk("arst_carry", {15'd0, CARRY}, 16'h0000);
        chk("arst_en",    {12'd0, EN}, 16'h0001);
        tick(1);
        RST = 1'b0;
        tick(8);
        chk("post_rst_idle", DIGIT, 16'h0000);
        chk("post_rst_run",  {15'd0, RUN}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
